// File: rtl/rom_dl_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rom_dl_ctrl_pkg
// Shared types and default parameters for the instruction-ROM download
// controller and its loader word buffer.
//   ADDR_W / DATA_W      : instruction bus widths (byte address, 32-bit word)
//   *_DEF                : default sizing for the production ROM and UART link
//   dl_state_t           : download sequencer states
//   dl_word_t            : one buffered loader word (address + data)
// ----------------------------------------------------------------------------
package rom_dl_ctrl_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;

    localparam int ROM_DEPTH_DEF      = 4096;
    localparam int FIFO_DEPTH_DEF     = 4;
    localparam int IDLE_TIMEOUT_DEF   = 208320;
    localparam int RELEASE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ERASE   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } dl_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dl_word_t;

endpackage

// File: rtl/rom_dl_fifo.sv
// ----------------------------------------------------------------------------
// rom_dl_fifo
// Small synchronous FIFO buffering loader words while the ROM port is busy.
// DEPTH must be a power of two, at least 2.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : discard all contents; a same-cycle push is kept
//   push, push_data : write one entry (ignored when full unless popping)
//   pop             : remove the head entry (ignored when empty or flushing)
//   pop_data        : head entry, valid whenever empty = 0
//   full, empty     : occupancy flags
// ----------------------------------------------------------------------------
module rom_dl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // A pop in the same cycle frees the slot a full-FIFO push needs; a flush
    // empties the FIFO first, so the push always fits and lands in slot 0.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop || flush);
    assign wr_idx  = flush ? '0 : wr_ptr[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= {{PTR_W{1'b0}}, push};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ----------------------------------------------------------------------------
// rom_dl_ctrl
// Sequences a program download from the UART loader into instruction ROM.
// Holds the core in reset while downloading, zero-fills the ROM on erase,
// buffers loader words that arrive mid-erase, ends the download after the
// loader line has been idle for IDLE_TIMEOUT cycles, then releases the core.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   dl_erase_i                  : loader erase request (1-cycle pulse)
//   dl_wr_en_i / addr / data    : loader word strobe, byte address, word
//   rom_we_o / waddr_o / wdata_o: registered ROM write port
//   core_hold_o                 : 1 while the core must stay in reset
//   dl_busy_o                   : 1 whenever not in RUN
//   dl_done_o                   : 1-cycle pulse when the core is released
//   dl_word_cnt_o               : loader words written this download (saturating)
//   dl_err_o                    : sticky [0] word dropped on full buffer,
//                                 [1] loader address beyond ROM
// ----------------------------------------------------------------------------
module rom_dl_ctrl
    import rom_dl_ctrl_pkg::*;
#(
    parameter int ROM_DEPTH      = ROM_DEPTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int IDLE_TIMEOUT   = IDLE_TIMEOUT_DEF,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_erase_i,
    input  logic              dl_wr_en_i,
    input  logic [ADDR_W-1:0] dl_wr_addr_i,
    input  logic [DATA_W-1:0] dl_wr_data_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [DATA_W-1:0] rom_wdata_o,
    output logic              core_hold_o,
    output logic              dl_busy_o,
    output logic              dl_done_o,
    output logic [15:0]       dl_word_cnt_o,
    output logic [1:0]        dl_err_o
);

    localparam int EADDR_W = $clog2(ROM_DEPTH) + 2;
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT);
    localparam int REL_W   = $clog2(RELEASE_CYCLES) + 1;

    localparam logic [ADDR_W-1:0]  ROM_BYTES  = ADDR_W'(ROM_DEPTH * 4);
    localparam logic [EADDR_W-1:0] ERASE_LAST = EADDR_W'((ROM_DEPTH - 1) * 4);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [REL_W-1:0]   REL_LAST   = REL_W'(RELEASE_CYCLES - 1);

    dl_state_t          state;
    logic               hold_q;
    logic [EADDR_W-1:0] erase_addr;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [REL_W-1:0]   rel_cnt;

    dl_word_t           fifo_in;
    dl_word_t           fifo_out;
    logic               fifo_full;
    logic               fifo_empty;

    logic               addr_ok;
    logic               push_req;
    logic               range_err;
    logic               start_erase;
    logic               pop;
    logic               overflow;

    assign addr_ok     = (dl_wr_addr_i < ROM_BYTES);
    assign push_req    = dl_wr_en_i && addr_ok;
    assign range_err   = dl_wr_en_i && !addr_ok;
    // Erase requests are ignored while an erase is already running.
    assign start_erase = dl_erase_i && (state != ST_ERASE);
    assign pop         = (state == ST_LOAD) && !fifo_empty && !start_erase;
    // A flush or a same-cycle pop both guarantee room for the new word.
    assign overflow    = push_req && fifo_full && !pop && !start_erase;

    assign fifo_in.addr = dl_wr_addr_i;
    assign fifo_in.data = dl_wr_data_i;

    rom_dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(dl_word_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_erase),
        .push      (push_req),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            hold_q        <= 1'b0;
            dl_done_o     <= 1'b0;
            rom_we_o      <= 1'b0;
            rom_waddr_o   <= '0;
            rom_wdata_o   <= '0;
            dl_word_cnt_o <= '0;
            dl_err_o      <= '0;
            erase_addr    <= '0;
            idle_cnt      <= '0;
            rel_cnt       <= '0;
        end else begin
            rom_we_o  <= 1'b0;
            dl_done_o <= 1'b0;

            if (pop) begin
                rom_we_o    <= 1'b1;
                rom_waddr_o <= fifo_out.addr;
                rom_wdata_o <= fifo_out.data;
                if (dl_word_cnt_o != 16'hFFFF) dl_word_cnt_o <= dl_word_cnt_o + 16'd1;
            end
            if (overflow)  dl_err_o[0] <= 1'b1;
            if (range_err) dl_err_o[1] <= 1'b1;

            if (start_erase) begin
                // A fresh download: stats reset, but a bad address arriving
                // together with the erase pulse is still reported.
                state         <= ST_ERASE;
                hold_q        <= 1'b1;
                erase_addr    <= '0;
                dl_word_cnt_o <= '0;
                dl_err_o      <= {range_err, 1'b0};
            end else begin
                case (state)
                    ST_RUN: begin
                        if (dl_wr_en_i) begin
                            state    <= ST_LOAD;
                            hold_q   <= 1'b1;
                            idle_cnt <= '0;
                        end
                    end
                    ST_ERASE: begin
                        rom_we_o    <= 1'b1;
                        rom_waddr_o <= ADDR_W'(erase_addr);
                        rom_wdata_o <= '0;
                        erase_addr  <= erase_addr + EADDR_W'(4);
                        if (erase_addr == ERASE_LAST) begin
                            state    <= ST_LOAD;
                            idle_cnt <= '0;
                        end
                    end
                    ST_LOAD: begin
                        // The counter parks at its last value while buffered
                        // words are still draining, so release waits for them.
                        if (dl_wr_en_i) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            if (fifo_empty) begin
                                state   <= ST_RELEASE;
                                rel_cnt <= '0;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (dl_wr_en_i) begin
                            state    <= ST_LOAD;
                            idle_cnt <= '0;
                        end else if (rel_cnt == REL_LAST) begin
                            state     <= ST_RUN;
                            hold_q    <= 1'b0;
                            dl_done_o <= 1'b1;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_RUN;
                        hold_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Busy and hold are the same condition: anything other than RUN.
    assign core_hold_o = hold_q;
    assign dl_busy_o   = hold_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rom_dl_ctrl
// Directed bench for rom_dl_ctrl with a 16-word ROM, 4-entry buffer,
// 100-cycle idle timeout and 4 release cycles. Inputs are driven and outputs
// sampled on the falling clock edge; ROM writes are logged as they appear.
// ----------------------------------------------------------------------------
module tb_rom_dl_ctrl;

    logic        clk;
    logic        rst_n;
    logic        dl_erase_i;
    logic        dl_wr_en_i;
    logic [31:0] dl_wr_addr_i;
    logic [31:0] dl_wr_data_i;
    logic        rom_we_o;
    logic [31:0] rom_waddr_o;
    logic [31:0] rom_wdata_o;
    logic        core_hold_o;
    logic        dl_busy_o;
    logic        dl_done_o;
    logic [15:0] dl_word_cnt_o;
    logic [1:0]  dl_err_o;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [63:0] wr_log [$];

    rom_dl_ctrl #(
        .ROM_DEPTH      (16),
        .FIFO_DEPTH     (4),
        .IDLE_TIMEOUT   (100),
        .RELEASE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dl_erase_i    (dl_erase_i),
        .dl_wr_en_i    (dl_wr_en_i),
        .dl_wr_addr_i  (dl_wr_addr_i),
        .dl_wr_data_i  (dl_wr_data_i),
        .rom_we_o      (rom_we_o),
        .rom_waddr_o   (rom_waddr_o),
        .rom_wdata_o   (rom_wdata_o),
        .core_hold_o   (core_hold_o),
        .dl_busy_o     (dl_busy_o),
        .dl_done_o     (dl_done_o),
        .dl_word_cnt_o (dl_word_cnt_o),
        .dl_err_o      (dl_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every ROM write as {address, data}, and count release pulses.
    always @(negedge clk) begin
        if (rst_n && rom_we_o) wr_log.push_back({rom_waddr_o, rom_wdata_o});
        if (rst_n && dl_done_o) done_count++;
    end

    // Drive one cycle of loader inputs across the next rising edge.
    task automatic applyStimulus(input logic erase, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        dl_erase_i   = erase;
        dl_wr_en_i   = wr;
        dl_wr_addr_i = addr;
        dl_wr_data_i = data;
        @(negedge clk);
        dl_erase_i   = 1'b0;
        dl_wr_en_i   = 1'b0;
        dl_wr_addr_i = '0;
        dl_wr_data_i = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // The zero-fill always occupies log entries 0..15 at addresses 0x00..0x3C.
    task automatic checkEraseRun(input string tag);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("%s_erase%0d", tag, i), wr_log[i], {32'(i * 4), 32'h0});
    endtask

    initial begin
        rst_n        = 1'b0;
        dl_erase_i   = 1'b0;
        dl_wr_en_i   = 1'b0;
        dl_wr_addr_i = '0;
        dl_wr_data_i = '0;
        idleCycles(3);

        checkOutput("rst_we",   rom_we_o,      0);
        checkOutput("rst_hold", core_hold_o,   0);
        checkOutput("rst_busy", dl_busy_o,     0);
        checkOutput("rst_done", dl_done_o,     0);
        checkOutput("rst_cnt",  dl_word_cnt_o, 0);
        checkOutput("rst_err",  dl_err_o,      0);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] erase from RUN with three words buffered during erase");
        wr_log.delete();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("a_hold", core_hold_o, 1);
        checkOutput("a_busy", dl_busy_o,   1);
        checkOutput("a_we0",  rom_we_o,    0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'hAAAA_0001);
        applyStimulus(1'b0, 1'b1, 32'h4, 32'hBBBB_0002);
        applyStimulus(1'b0, 1'b1, 32'h8, 32'hCCCC_0003);
        idleCycles(25);
        checkOutput("a_log_size", wr_log.size(), 19);
        checkEraseRun("a");
        checkOutput("a_word0", wr_log[16], {32'h0, 32'hAAAA_0001});
        checkOutput("a_word1", wr_log[17], {32'h4, 32'hBBBB_0002});
        checkOutput("a_word2", wr_log[18], {32'h8, 32'hCCCC_0003});
        checkOutput("a_cnt",   dl_word_cnt_o, 3);
        checkOutput("a_err",   dl_err_o, 0);
        checkOutput("a_hold2", core_hold_o, 1);

        $display("[TB] six words during erase overflow the buffer");
        wr_log.delete();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("b_cnt_clr", dl_word_cnt_o, 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 32'(32'h10 + i * 4), 32'(32'hD000_0000 + i));
        idleCycles(25);
        checkOutput("b_log_size", wr_log.size(), 20);
        checkEraseRun("b");
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("b_word%0d", i), wr_log[16 + i],
                        {32'(32'h10 + i * 4), 32'(32'hD000_0000 + i)});
        checkOutput("b_err", dl_err_o, 2'b01);
        checkOutput("b_cnt", dl_word_cnt_o, 4);

        $display("[TB] out-of-range address then the last legal word");
        wr_log.delete();
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hBAD0_0040);
        checkOutput("c_err_range", dl_err_o, 2'b11);
        applyStimulus(1'b0, 1'b1, 32'h3C, 32'h1234_5678);
        idleCycles(3);
        checkOutput("c_log_size", wr_log.size(), 1);
        checkOutput("c_word",     wr_log[0], {32'h3C, 32'h1234_5678});
        checkOutput("c_cnt",      dl_word_cnt_o, 5);

        $display("[TB] idle timeout, release and core un-hold");
        idleCycles(96);
        checkOutput("d_hold_99",  core_hold_o, 1);
        checkOutput("d_done_99",  dl_done_o,   0);
        idleCycles(4);
        checkOutput("d_hold_103", core_hold_o, 1);
        checkOutput("d_busy_103", dl_busy_o,   1);
        checkOutput("d_done_103", dl_done_o,   0);
        idleCycles(1);
        checkOutput("d_done_104", dl_done_o,   1);
        checkOutput("d_hold_104", core_hold_o, 0);
        checkOutput("d_busy_104", dl_busy_o,   0);
        idleCycles(1);
        checkOutput("d_done_105", dl_done_o,   0);
        checkOutput("d_done_cnt", done_count,  1);
        checkOutput("d_err_kept", dl_err_o,    2'b11);

        $display("[TB] erase and word together in LOAD flush the buffer");
        wr_log.delete();
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h5555_0020);
        checkOutput("e_hold_load", core_hold_o, 1);
        applyStimulus(1'b1, 1'b1, 32'h24, 32'h6666_0024);
        checkOutput("e_err_clr", dl_err_o, 0);
        checkOutput("e_cnt_clr", dl_word_cnt_o, 0);
        idleCycles(25);
        checkOutput("e_log_size", wr_log.size(), 17);
        checkEraseRun("e");
        checkOutput("e_word", wr_log[16], {32'h24, 32'h6666_0024});
        checkOutput("e_cnt",  dl_word_cnt_o, 1);

        $display("[TB] reset in the middle of an erase");
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        idleCycles(3);
        rst_n = 1'b0;
        #1;
        checkOutput("f_hold", core_hold_o,   0);
        checkOutput("f_busy", dl_busy_o,     0);
        checkOutput("f_we",   rom_we_o,      0);
        checkOutput("f_cnt",  dl_word_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(5);
        checkOutput("f_we_after",   rom_we_o,    0);
        checkOutput("f_hold_after", core_hold_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
